// File: rtl/axil_uart_sequencer_if.sv
// AXI4-Lite bundle between the UART sequencer (master) and the UART register slave.
interface axil_uart_sequencer_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR;
  logic                              M_AXI_AWVALID;
  logic                              M_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTB;
  logic                              M_AXI_WVALID;
  logic                              M_AXI_WREADY;
  logic [1:0]                        M_AXI_BRESP;
  logic                              M_AXI_BVALID;
  logic                              M_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR;
  logic                              M_AXI_ARVALID;
  logic                              M_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA;
  logic [1:0]                        M_AXI_RRESP;
  logic                              M_AXI_RVALID;
  logic                              M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/axil_uart_sequencer.sv
// AXI4-Lite master that initialises the UART, polls STAT and pushes a 1-entry TX hold into the TX FIFO.
// Define UART_SEQ_RX_EN to also drain the RX FIFO onto rx_data/rx_valid.
module axil_uart_sequencer #(
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int POLL_GAP = 16,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_RX   = 4'h0,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_TX   = 4'h4,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_STAT = 4'h8,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_CTRL = 4'hC
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  err,
  axil_uart_sequencer_if.master m_axi
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [7:0]    GAP_RELOAD    = 8'(POLL_GAP);
  localparam logic [DW-1:0] CTRL_FIFO_RST = DW'(3);
`ifdef UART_SEQ_RX_EN
  localparam logic RX_EN = 1'b1;
`else
  localparam logic RX_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_POLL, S_DECIDE, S_TXW
`ifdef UART_SEQ_RX_EN
    , S_RXR
`endif
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_awvalid, w_awvalid_nxt;
  logic          r_wvalid, w_wvalid_nxt;
  logic          r_bready, w_bready_nxt;
  logic          r_arvalid, w_arvalid_nxt;
  logic          r_rready, w_rready_nxt;
  logic [AW-1:0] r_awaddr, w_awaddr_nxt;
  logic [AW-1:0] r_araddr, w_araddr_nxt;
  logic [DW-1:0] r_wdata, w_wdata_nxt;
  logic [7:0]    r_hold, w_hold_nxt;
  logic          r_hold_full, w_hold_full_nxt;
  logic          r_tx_ready, w_tx_ready_nxt;
  logic [7:0]    r_gap, w_gap_nxt;
  logic [7:0]    r_stat, w_stat_nxt;
  logic          r_err, w_err_nxt;
`ifdef UART_SEQ_RX_EN
  logic [7:0]    r_rx_data, w_rx_data_nxt;
  logic          r_rx_valid, w_rx_valid_nxt;
`endif

  logic          w_issue_wr, w_issue_rd;
  logic [AW-1:0] w_req_addr;
  logic [DW-1:0] w_req_data;
  logic          w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic          w_poll_en;

  assign w_aw_hs   = r_awvalid && m_axi.M_AXI_AWREADY;
  assign w_w_hs    = r_wvalid  && m_axi.M_AXI_WREADY;
  assign w_b_hs    = r_bready  && m_axi.M_AXI_BVALID;
  assign w_ar_hs   = r_arvalid && m_axi.M_AXI_ARREADY;
  assign w_r_hs    = r_rready  && m_axi.M_AXI_RVALID;
  // Without an RX path there is nothing to poll for until a byte is held.
  assign w_poll_en = r_hold_full || RX_EN;

  always_comb begin
    w_state_nxt     = r_state;
    w_busy_nxt      = r_busy;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_awaddr_nxt    = r_awaddr;
    w_araddr_nxt    = r_araddr;
    w_wdata_nxt     = r_wdata;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_gap_nxt       = r_gap;
    w_stat_nxt      = r_stat;
    w_err_nxt       = r_err;
    w_issue_wr      = 1'b0;
    w_issue_rd      = 1'b0;
    w_req_addr      = '0;
    w_req_data      = '0;
`ifdef UART_SEQ_RX_EN
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = r_rx_valid;
    if (r_rx_valid && rx_ready) w_rx_valid_nxt = 1'b0;
`endif

    case (r_state)
      S_INIT: begin
        if (!r_busy) begin
          w_issue_wr = 1'b1;
          w_req_addr = ADDR_CTRL;
          w_req_data = CTRL_FIFO_RST;
        end else if (w_b_hs) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (!w_poll_en)       w_gap_nxt = GAP_RELOAD;
        else if (r_gap == '0) w_state_nxt = S_POLL;
        else                  w_gap_nxt = r_gap - 8'd1;
      end
      S_POLL: begin
        if (!r_busy) begin
          w_issue_rd = 1'b1;
          w_req_addr = ADDR_STAT;
        end else if (w_r_hs) begin
          w_stat_nxt  = m_axi.M_AXI_RDATA[7:0];
          w_state_nxt = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (r_hold_full && !r_stat[3]) begin
          w_state_nxt = S_TXW;
`ifdef UART_SEQ_RX_EN
        end else if (r_stat[0] && !r_rx_valid) begin
          w_state_nxt = S_RXR;
`endif
        end else begin
          w_gap_nxt   = GAP_RELOAD;
          w_state_nxt = S_IDLE;
        end
      end
      S_TXW: begin
        if (!r_busy) begin
          w_issue_wr = 1'b1;
          w_req_addr = ADDR_TX;
          w_req_data = {{(DW-8){1'b0}}, r_hold};
        end else if (w_b_hs) begin
          // An errored write still retires the byte; err records the loss.
          w_hold_full_nxt = 1'b0;
          w_state_nxt     = S_POLL;
        end
      end
`ifdef UART_SEQ_RX_EN
      S_RXR: begin
        if (!r_busy) begin
          w_issue_rd = 1'b1;
          w_req_addr = ADDR_RX;
        end else if (w_r_hs) begin
          if (m_axi.M_AXI_RRESP == 2'b00) begin
            w_rx_data_nxt  = m_axi.M_AXI_RDATA[7:0];
            w_rx_valid_nxt = 1'b1;
          end
          w_state_nxt = S_POLL;
        end
      end
`endif
      default: w_state_nxt = S_INIT;
    endcase

    if (w_aw_hs) w_awvalid_nxt = 1'b0;
    if (w_w_hs)  w_wvalid_nxt  = 1'b0;
    if (w_b_hs) begin
      w_bready_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      if (m_axi.M_AXI_BRESP != 2'b00) w_err_nxt = 1'b1;
    end
    if (w_ar_hs) begin
      w_arvalid_nxt = 1'b0;
      w_rready_nxt  = 1'b1;
    end
    if (w_r_hs) begin
      w_rready_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      if (m_axi.M_AXI_RRESP != 2'b00) w_err_nxt = 1'b1;
    end
    if (w_issue_wr) begin
      w_awvalid_nxt = 1'b1;
      w_wvalid_nxt  = 1'b1;
      w_bready_nxt  = 1'b1;
      w_awaddr_nxt  = w_req_addr;
      w_wdata_nxt   = w_req_data;
      w_busy_nxt    = 1'b1;
    end
    if (w_issue_rd) begin
      w_arvalid_nxt = 1'b1;
      w_araddr_nxt  = w_req_addr;
      w_busy_nxt    = 1'b1;
    end

    // Accept wins over a same-cycle retire so a new byte is never dropped.
    if (tx_valid && r_tx_ready) begin
      w_hold_nxt      = tx_data;
      w_hold_full_nxt = 1'b1;
    end
    w_tx_ready_nxt = !w_hold_full_nxt;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_state     <= S_INIT;
      r_busy      <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_gap       <= GAP_RELOAD;
      r_stat      <= '0;
      r_err       <= 1'b0;
`ifdef UART_SEQ_RX_EN
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= w_busy_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_awaddr    <= w_awaddr_nxt;
      r_araddr    <= w_araddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_tx_ready  <= w_tx_ready_nxt;
      r_gap       <= w_gap_nxt;
      r_stat      <= w_stat_nxt;
      r_err       <= w_err_nxt;
`ifdef UART_SEQ_RX_EN
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
`endif
    end
  end

  assign tx_ready            = r_tx_ready;
  assign err                 = r_err;
`ifdef UART_SEQ_RX_EN
  assign rx_data             = r_rx_data;
  assign rx_valid            = r_rx_valid;
`else
  assign rx_data             = '0;
  assign rx_valid            = 1'b0;
`endif
  assign m_axi.M_AXI_AWADDR  = r_awaddr;
  assign m_axi.M_AXI_AWVALID = r_awvalid;
  assign m_axi.M_AXI_WDATA   = r_wdata;
  assign m_axi.M_AXI_WSTB    = '1;
  assign m_axi.M_AXI_WVALID  = r_wvalid;
  assign m_axi.M_AXI_BREADY  = r_bready;
  assign m_axi.M_AXI_ARADDR  = r_araddr;
  assign m_axi.M_AXI_ARVALID = r_arvalid;
  assign m_axi.M_AXI_RREADY  = r_rready;
endmodule

// File: tb/tb_axil_uart_sequencer.sv
// Bench for axil_uart_sequencer: UART slave model at the negative edge, vector table, random bytes.
`timescale 1ns/1ps
module tb_axil_uart_sequencer;
  localparam int POLL_GAP = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       err;

  always #5 clk = ~clk;

  axil_uart_sequencer_if #(.C_S_AXI_ADDR_WIDTH(4), .C_S_AXI_DATA_WIDTH(32)) bus ();

  axil_uart_sequencer #(.POLL_GAP(POLL_GAP)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .err(err), .m_axi(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- UART slave model ----------------
  int aw_delay = 0, w_delay = 0, ar_delay = 0;
  int aw_ctr, w_ctr, ar_ctr, aw_wait_last, w_wait_last;
  logic p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
  logic [3:0]  p_awaddr, p_araddr, got_awaddr, r_addr;
  logic [31:0] p_wdata, got_wdata;
  bit aw_got, w_got, r_pend, b_is_tx;
  logic [7:0] stat_q[$];
  logic [1:0] bresp_q[$];
  logic [7:0] stat_dflt = 8'h04;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] s_byte;
  logic [3:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int polls_q[$];
  int stat_cyc_q[$];
  int n_stat, n_rx_reads, n_reads_total, viol, cyc;
  logic b_txready;

  initial begin
    bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = 0;
    bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0; bus.M_AXI_RRESP = 0; bus.M_AXI_RDATA = 0;
    {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
    {aw_got, w_got, r_pend, b_is_tx} = '0;
    aw_ctr = 0; w_ctr = 0; ar_ctr = 0; aw_wait_last = -1; w_wait_last = -1;
    n_stat = 0; n_rx_reads = 0; n_reads_total = 0; viol = 0; cyc = 0; b_txready = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
        bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0;
        {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
        {aw_got, w_got, r_pend} = '0;
        aw_ctr = 0; w_ctr = 0; ar_ctr = 0;
      end else begin
        // handshakes completed at the rising edge just passed
        if (p_awv && p_awr) begin aw_got = 1; got_awaddr = p_awaddr; end
        if (p_wv && p_wr) begin w_got = 1; got_wdata = p_wdata; end
        if (p_bv && p_br) begin
          bus.M_AXI_BVALID = 0;
          if (b_is_tx) b_txready = tx_ready;
        end
        if (p_arv && p_arr) begin
          r_pend = 1; r_addr = p_araddr; n_reads_total++;
          if (p_araddr == 4'h8 && wr_addr_q.size() == 0) begin n_stat++; stat_cyc_q.push_back(cyc); end
          if (p_araddr == 4'h0) n_rx_reads++;
        end
        if (p_rv && p_rr) bus.M_AXI_RVALID = 0;
        if (aw_got && w_got) begin
          wr_addr_q.push_back(got_awaddr); wr_data_q.push_back(got_wdata); polls_q.push_back(n_stat);
          b_is_tx = (got_awaddr == 4'h4);
          bus.M_AXI_BRESP = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
          bus.M_AXI_BVALID = 1; aw_got = 0; w_got = 0;
        end
        if (r_pend && !bus.M_AXI_RVALID) begin
          if (r_addr == 4'h8) s_byte = (stat_q.size() > 0) ? stat_q.pop_front() : stat_dflt;
          else s_byte = rx_byte;
          bus.M_AXI_RDATA = {24'hABCDEF, s_byte};
          bus.M_AXI_RRESP = 2'b00; bus.M_AXI_RVALID = 1; r_pend = 0;
        end
        // a VALID not yet accepted must persist with unchanged payload; AW and W rise together
        if (p_awv && !p_awr && (!bus.M_AXI_AWVALID || bus.M_AXI_AWADDR != p_awaddr)) viol++;
        if (p_wv && !p_wr && (!bus.M_AXI_WVALID || bus.M_AXI_WDATA != p_wdata)) viol++;
        if (p_arv && !p_arr && (!bus.M_AXI_ARVALID || bus.M_AXI_ARADDR != p_araddr)) viol++;
        if ((bus.M_AXI_AWVALID && !p_awv) != (bus.M_AXI_WVALID && !p_wv)) viol++;
        if (bus.M_AXI_WVALID && bus.M_AXI_WSTB != 4'hF) viol++;
        // ready generation for the next edge
        if (bus.M_AXI_AWVALID) begin
          bus.M_AXI_AWREADY = (aw_ctr >= aw_delay);
          if (bus.M_AXI_AWREADY) begin aw_wait_last = aw_ctr; aw_ctr = 0; end else aw_ctr++;
        end else begin bus.M_AXI_AWREADY = 0; aw_ctr = 0; end
        if (bus.M_AXI_WVALID) begin
          bus.M_AXI_WREADY = (w_ctr >= w_delay);
          if (bus.M_AXI_WREADY) begin w_wait_last = w_ctr; w_ctr = 0; end else w_ctr++;
        end else begin bus.M_AXI_WREADY = 0; w_ctr = 0; end
        if (bus.M_AXI_ARVALID) begin
          bus.M_AXI_ARREADY = (ar_ctr >= ar_delay);
          if (bus.M_AXI_ARREADY) ar_ctr = 0; else ar_ctr++;
        end else begin bus.M_AXI_ARREADY = 0; ar_ctr = 0; end
        p_awv = bus.M_AXI_AWVALID; p_awr = bus.M_AXI_AWREADY; p_awaddr = bus.M_AXI_AWADDR;
        p_wv  = bus.M_AXI_WVALID;  p_wr  = bus.M_AXI_WREADY;  p_wdata  = bus.M_AXI_WDATA;
        p_bv  = bus.M_AXI_BVALID;  p_br  = bus.M_AXI_BREADY;
        p_arv = bus.M_AXI_ARVALID; p_arr = bus.M_AXI_ARREADY; p_araddr = bus.M_AXI_ARADDR;
        p_rv  = bus.M_AXI_RVALID;  p_rr  = bus.M_AXI_RREADY;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); polls_q.delete(); stat_cyc_q.delete(); stat_q.delete();
    n_stat = 0; b_txready = 0;
  endtask

  task automatic wait_wr(input string name, input int budget);
    int i = 0;
    while (wr_addr_q.size() == 0 && i < budget) begin @(negedge clk); i++; end
    check({name, "_wr_seen"}, 32'(wr_addr_q.size() > 0), 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int i = 0;
    while (!tx_ready && i < 500) begin @(negedge clk); i++; end
    tx_data = b; tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
  endtask

  typedef struct {
    logic [7:0]  data;
    int          nfull;
    logic [1:0]  bresp;
    int          aw_dly;
    int          w_dly;
    int          exp_polls;
    logic [31:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    logic [3:0]  a;
    logic [31:0] d;
    int p, mg;
    clear_logs();
    aw_delay = v.aw_dly; w_delay = v.w_dly;
    for (int n = 0; n < v.nfull; n++) stat_q.push_back(8'h08);
    stat_q.push_back(8'h04);
    bresp_q.push_back(v.bresp);
    send_byte(v.data);
    wait_wr(tag, 3000);
    a = (wr_addr_q.size() > 0) ? wr_addr_q[0] : 4'hx;
    d = (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx;
    p = (polls_q.size() > 0) ? polls_q[0] : -1;
    check({tag, "_awaddr"}, 32'(a), 32'h4);
    check({tag, "_wdata"}, d, v.exp_wdata);
`ifndef UART_SEQ_RX_EN
    check({tag, "_stat_polls"}, 32'(p), 32'(v.exp_polls));
`endif
    if (v.nfull > 0) begin
      mg = 1 << 30;
      for (int n = 1; n < stat_cyc_q.size(); n++)
        if (stat_cyc_q[n] - stat_cyc_q[n-1] < mg) mg = stat_cyc_q[n] - stat_cyc_q[n-1];
      check({tag, "_poll_gap_ok"}, 32'(mg >= POLL_GAP + 1), 1);
    end
    check({tag, "_aw_wait"}, 32'(aw_wait_last), 32'(v.aw_dly));
    check({tag, "_w_wait"}, 32'(w_wait_last), 32'(v.w_dly));
    repeat (40) @(negedge clk);
    check({tag, "_tx_ready_after_b"}, 32'(b_txready), 1);
    check({tag, "_err"}, 32'(err), 32'(v.exp_err));
    aw_delay = 0; w_delay = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[5];
    vec_t rv;
    logic err_model;
    int k;
    vecs[0] = '{8'h41, 0, 2'b00, 0, 0, 1, 32'h0000_0041, 1'b0};
    vecs[1] = '{8'hA5, 3, 2'b00, 0, 0, 4, 32'h0000_00A5, 1'b0};
    vecs[2] = '{8'h77, 0, 2'b00, 5, 0, 1, 32'h0000_0077, 1'b0};
    vecs[3] = '{8'h00, 1, 2'b00, 2, 3, 2, 32'h0000_0000, 1'b0};
    vecs[4] = '{8'hC3, 0, 2'b10, 0, 0, 1, 32'h0000_00C3, 1'b1};

    rst_n = 0; tx_valid = 0; tx_data = 0; rx_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_valids", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}), 0);
    check("rst_readies", 32'({bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 0);
    check("rst_tx_ready", 32'(tx_ready), 0);
    check("rst_err_rxv", 32'({err, rx_valid}), 0);
    check("rst_addr", 32'({bus.M_AXI_AWADDR, bus.M_AXI_ARADDR}), 0);
    check("rst_wdata", bus.M_AXI_WDATA, 0);

    rst_n = 1;
    clear_logs();
    wait_wr("init", 100);
    check("init_awaddr", 32'((wr_addr_q.size() > 0) ? wr_addr_q[0] : 4'hx), 32'hC);
    check("init_wdata", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx, 32'h3);
    repeat (60) @(negedge clk);
`ifndef UART_SEQ_RX_EN
    check("no_poll_when_empty", 32'(n_reads_total), 0);
`endif
    check("tx_ready_idle", 32'(tx_ready), 1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    check("protocol_violations_table", 32'(viol), 0);

    // Random bytes against a byte-in/byte-out model; err stays sticky after the SLVERR vector.
    err_model = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rv.data      = 8'($urandom_range(0, 255));
      rv.nfull     = $urandom_range(0, 2);
      rv.bresp     = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      rv.aw_dly    = $urandom_range(0, 3);
      rv.w_dly     = $urandom_range(0, 3);
      rv.exp_polls = rv.nfull + 1;
      rv.exp_wdata = {24'h0, rv.data};
      err_model    = err_model | (rv.bresp != 2'b00);
      rv.exp_err   = err_model;
      ar_delay     = $urandom_range(0, 2);
      run_vec(rv, $sformatf("rnd%0d", i));
    end
    ar_delay = 0;
    check("protocol_violations_rand", 32'(viol), 0);

`ifdef UART_SEQ_RX_EN
    rx_ready = 0; rx_byte = 8'h5A; n_rx_reads = 0; stat_dflt = 8'h01;
    k = 0;
    while (!rx_valid && k < 500) begin @(negedge clk); k++; end
    check("rx_valid_set", 32'(rx_valid), 1);
    check("rx_data", 32'(rx_data), 32'h5A);
    rx_byte = 8'h3C;
    repeat (100) @(negedge clk);
    check("rx_no_reread", 32'(n_rx_reads), 1);
    check("rx_data_held", 32'(rx_data), 32'h5A);
    rx_ready = 1;
    @(negedge clk);
    rx_ready = 0;
    k = 0;
    while (!(rx_valid && rx_data == 8'h3C) && k < 500) begin @(negedge clk); k++; end
    check("rx_second_byte", 32'(rx_data), 32'h3C);
    check("rx_reads_after_ack", 32'(n_rx_reads), 2);
    stat_dflt = 8'h04; rx_ready = 1;
    repeat (40) @(negedge clk);
    rx_ready = 0;
`endif

    // Reset while an AR is stalled must drop ARVALID at the next edge.
    ar_delay = 100000;
    send_byte(8'h99);
    k = 0;
    while (!bus.M_AXI_ARVALID && k < 300) begin @(negedge clk); k++; end
    check("ar_pending", 32'(bus.M_AXI_ARVALID), 1);
    rst_n = 0;
    @(negedge clk);
    check("rst_drops_arvalid", 32'(bus.M_AXI_ARVALID), 0);
    check("rst_clears_err", 32'(err), 0);
    check("rst_tx_ready_low", 32'(tx_ready), 0);
    ar_delay = 0;
    @(negedge clk);
    clear_logs();
    rst_n = 1;
    wait_wr("reinit", 100);
    check("reinit_awaddr", 32'((wr_addr_q.size() > 0) ? wr_addr_q[0] : 4'hx), 32'hC);
    repeat (40) @(negedge clk);
    check("reinit_hold_empty", 32'(tx_ready), 1);
    check("protocol_violations_end", 32'(viol), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
